// File: rtl/wbu_commit_if.sv
// Execute-to-writeback result handshake: one result per valid/ready transfer.
interface wbu_commit_if #(
    parameter int unsigned XLEN = 64
);
    logic            exu_valid;
    logic            exu_ready;
    logic [XLEN-1:0] exu_pc;
    logic [4:0]      exu_rd;
    logic            exu_rd_wen;
    logic [XLEN-1:0] exu_dst_data;
    logic            exu_ecall;
    logic            exu_ebreak;

    modport master (
        output exu_valid,
        output exu_pc,
        output exu_rd,
        output exu_rd_wen,
        output exu_dst_data,
        output exu_ecall,
        output exu_ebreak,
        input  exu_ready
    );

    modport slave (
        input  exu_valid,
        input  exu_pc,
        input  exu_rd,
        input  exu_rd_wen,
        input  exu_dst_data,
        input  exu_ecall,
        input  exu_ebreak,
        output exu_ready
    );
endinterface

// File: rtl/wbu_commit.sv
// RV64 write-back/commit stage: in-order result FIFO draining into the regfile port.
// Optional WBU_TRACE_EN: prints a commit trace and the trap verdict on halt.
module wbu_commit #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    wbu_commit_if.slave      exu,
    input  logic             wb_stall,
    input  logic [XLEN-1:0]  a0_data,
    output logic             rf_wen,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             commit_valid,
    output logic [XLEN-1:0]  commit_pc,
    output logic             halt,
    output logic [XLEN-1:0]  halt_code,
    output logic [63:0]      retire_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            rd_wen;
        logic [XLEN-1:0] data;
        logic            ecall;
        logic            ebreak;
    } entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ready_q, ready_d;
    logic            rf_wen_q, rf_wen_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            commit_valid_q, commit_valid_d;
    logic [XLEN-1:0] commit_pc_q, commit_pc_d;
    logic            halt_q, halt_d;
    logic [XLEN-1:0] halt_code_q, halt_code_d;
    logic [63:0]     retire_cnt_q, retire_cnt_d;

    entry_t          mem_q [FIFO_DEPTH];
    entry_t          head;
    entry_t          wr_entry;
    logic            empty;
    logic            push;
    logic            pop;

    // Full when the index bits match but the wrap bits differ.
    function automatic logic ptr_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
        return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign push  = exu.exu_valid && ready_q;
    assign pop   = (state_q == RUN) && !empty && !wb_stall;

    assign wr_entry = '{
        pc:     exu.exu_pc,
        rd:     exu.exu_rd,
        rd_wen: exu.exu_rd_wen,
        data:   exu.exu_dst_data,
        ecall:  exu.exu_ecall,
        ebreak: exu.exu_ebreak
    };

    // Next-state and registered-output computation.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        rf_wen_d       = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        commit_valid_d = 1'b0;
        commit_pc_d    = commit_pc_q;
        halt_d         = halt_q;
        halt_code_d    = halt_code_q;
        retire_cnt_d   = retire_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        case (state_q)
            RUN: begin
                if (pop) begin
                    rd_ptr_d       = rd_ptr_q + PW'(1);
                    rf_wen_d       = head.rd_wen && (head.rd != 5'd0) && !head.ecall && !head.ebreak;
                    rf_waddr_d     = head.rd;
                    rf_wdata_d     = head.data;
                    commit_valid_d = 1'b1;
                    commit_pc_d    = head.pc;
                    retire_cnt_d   = retire_cnt_q + 64'd1;
                    if (head.ebreak) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                        // The write to x10 landing at this edge is not yet visible on a0_data.
                        halt_code_d = (rf_wen_q && (rf_waddr_q == 5'd10)) ? rf_wdata_q : a0_data;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        ready_d = (state_d == RUN) && !ptr_full(wr_ptr_d, rd_ptr_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            ready_q        <= 1'b1;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            halt_q         <= 1'b0;
            halt_code_q    <= '0;
            retire_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            ready_q        <= ready_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            halt_q         <= halt_d;
            halt_code_q    <= halt_code_d;
            retire_cnt_q   <= retire_cnt_d;
        end
    end

    // Storage has no reset; occupancy is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    assign exu.exu_ready = ready_q;
    assign rf_wen        = rf_wen_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;
    assign commit_valid  = commit_valid_q;
    assign commit_pc     = commit_pc_q;
    assign halt          = halt_q;
    assign halt_code     = halt_code_q;
    assign retire_cnt    = retire_cnt_q;

`ifdef WBU_TRACE_EN
    // Halt only ever rises together with the EBREAK's own commit cycle.
    always_ff @(posedge clk) begin
        if (rst_n && commit_valid_q) begin
            $display("[WBU] pc=%h rd=x%0d data=%h wen=%0d", commit_pc_q, rf_waddr_q, rf_wdata_q, rf_wen_q);
            if (halt_q) begin
                if (halt_code_q == '0) begin
                    $display("[WBU] HIT GOOD TRAP at pc=%h", commit_pc_q);
                end else begin
                    $display("[WBU] HIT BAD TRAP at pc=%h code=%h", commit_pc_q, halt_code_q);
                end
            end
        end
    end
`else
`endif

endmodule

// File: doc/wbu_commit.md
Name: wbu_commit

Overview:
- Write-back/commit stage of the RV64 core.
- Receives ALU/LSU results (destination data, rd, pc, ecall/ebreak flags) over a valid/ready handshake and buffers them in an in-order FIFO.
- Drains one entry per cycle into the register-file write port and publishes a commit stream, a retire counter, and an EBREAK halt with its exit code.

Parameters:
- XLEN, 64, data/pc width
- FIFO_DEPTH, 2, buffer entries; power of two, >= 2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- exu_valid  in  1  result presented
- exu_ready  out  1  wbu can accept
- exu_pc  in  XLEN  pc of instruction
- exu_rd  in  5  destination register
- exu_rd_wen  in  1  instruction writes rd
- exu_dst_data  in  XLEN  result data
- exu_ecall  in  1  instruction is ECALL
- exu_ebreak  in  1  instruction is EBREAK
- wb_stall  in  1  inhibit pop this cycle
- a0_data  in  XLEN  current regfile x10, combinational read
- rf_wen  out  1  regfile write enable
- rf_waddr  out  5  regfile write address
- rf_wdata  out  XLEN  regfile write data
- commit_valid  out  1  one instruction retired this cycle
- commit_pc  out  XLEN  pc of retired instruction
- halt  out  1  EBREAK retired, core halted
- halt_code  out  XLEN  a0 value at EBREAK
- retire_cnt  out  64  retired-instruction count

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all outputs 0 except exu_ready; FIFO empty; state RUN; exu_ready=1 after reset.
- States:
  - RUN: normal operation.
  - HALTED: exu_ready=0, no pops, FIFO contents frozen, halt=1. Exited only by reset.
- Enqueue: on the edge where exu_valid && exu_ready. Capture pc, rd, rd_wen, data, ecall, ebreak.
- exu_ready = (state==RUN) && !full.
  - Depends only on current occupancy; a pop in the same cycle does not allow enqueue when full.
- Pop: when state==RUN && !empty && !wb_stall, the head pops at the edge.
- All rf_*/commit_* outputs are registered from the popped head.
  - They are valid during the cycle after the pop edge and are 0/unchanged-deasserted otherwise (rf_wen=0, commit_valid=0).
- Latency: handshake at edge t, empty FIFO, no stall → rf_wen/commit_valid high in the cycle after edge t+1.
- Throughput: one commit per cycle sustained.
- Write suppression:
  - rf_wen = rd_wen && rd!=0 && !ecall && !ebreak.
  - rf_waddr/rf_wdata are still loaded from the head when rf_wen=0.
- commit_valid=1 for every pop, including x0, ECALL and EBREAK entries.
- ECALL: commits, no write, no state change.
- EBREAK pop:
  - state→HALTED and halt=1 from the next cycle.
  - halt_code = a0 value at the pop edge.
  - If rf_wen && rf_waddr==10 in that cycle, forward rf_wdata; otherwise use a0_data.
  - Entries behind the EBREAK are never committed.
- retire_cnt: +1 per commit_valid cycle, updated in the same cycle commit_valid is high. Wraps 2^64-1 → 0.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits with wrap bit; full/empty from pointer compare.
  - Simultaneous push and pop when not full and not empty: occupancy unchanged.
  - Push into empty with pop blocked: occupancy 1.
- wb_stall while HALTED: no effect.
- Reset mid-operation: FIFO flushed, counters and halt cleared immediately, no partial commit.

Optional Feature:
- WBU_TRACE_EN
- Defined:
  - On every commit_valid cycle, $display pc, rd, data, and whether written.
  - On halt, $display "HIT GOOD TRAP" if halt_code==0, else "HIT BAD TRAP" with halt_code.
- Undefined: no $display statements compiled; identical port behaviour and timing.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → all outputs 0 asynchronously; release → exu_ready=1, retire_cnt=0.
- Single write: pc=0x80000000, rd=5, rd_wen=1, data=0x1234 → two edges later rf_wen=1, rf_waddr=5, rf_wdata=0x1234, commit_pc=0x80000000, retire_cnt=1.
- x0 and ECALL: rd=0 data=0xFFFF rd_wen=1, then ECALL → commit_valid on two consecutive cycles, rf_wen=0 both, retire_cnt=2.
- Backpressure: wb_stall=1, push 2 entries → exu_ready=0 with FIFO full, third held. Release stall → entries commit in order on consecutive cycles, third accepted and commits next.
- EBREAK forwarding: push rd=10 data=0, then EBREAK back-to-back while a0_data=0x7 → halt=1, halt_code=0 (forwarded). A later push is refused (exu_ready=0); retire_cnt stays 2.
- Reset while HALTED with 1 queued entry → halt=0, FIFO empty, no commit of the queued entry after release.
